// File: rtl/trace_buf_pkg.sv
// Shared types and constants for the multi-channel trace capture buffer.
package trace_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_POST = 2'd2,
    ST_STOP = 2'd3
  } trace_state_e;

  localparam int          TS_W     = 16;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/trace_buf_sdpram.sv
// Inferred simple-dual-port RAM with a registered read port (1-cycle read latency).
module trace_buf_sdpram #(
  parameter int WIDTH = 33,
  parameter int AW    = 10
) (
  input  logic             user_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rd_dat_q;

  always_ff @(posedge user_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/trace_buf_mc.sv
// Multi-channel trace capture buffer: round-robin capture into one RAM, oldest-first readout.
// Optional TRACE_BUF_TIMESTAMP_EN prepends a 16-bit free-running timestamp to every entry.
module trace_buf_mc
  import trace_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int CH_NUM     = 2,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
`ifdef TRACE_BUF_TIMESTAMP_EN
  localparam int RD_W      = TS_W + CH_W + DATA_W
`else
  localparam int RD_W      = CH_W + DATA_W
`endif
) (
  input  logic                     user_clk,
  input  logic                     reset_n,
  input  logic                     trace_clr,
  input  logic                     trace_enb,
  input  logic                     trace_mode,
  input  logic [CH_NUM-1:0]        trace_we,
  input  logic [CH_NUM*DATA_W-1:0] trace_wd,
  input  logic                     trace_trig,
  input  logic [DEPTH_LOG2-1:0]    trace_post,
  input  logic                     trace_re,
  output logic [RD_W-1:0]          trace_rd,
  output logic                     trace_rd_vld,
  output logic [DEPTH_LOG2:0]      trace_cnt,
  output logic [15:0]              trace_drop,
  output logic [1:0]               trace_state
);

  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CH_W-1:0]       LAST_RST = CH_W'(CH_NUM - 1);

  trace_state_e          state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] post_q, post_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [15:0]           drop_q, drop_d;
  logic [CH_W-1:0]       last_q, last_d;
  logic                  vld1_q, vld1_d;
  logic                  vld2_q, vld2_d;
  logic [RD_W-1:0]       rd_dat_q, rd_dat_d;

  logic                  hi_vld, lo_vld, win_vld;
  logic [CH_W-1:0]       hi_id, lo_id, win_id;
  logic [DATA_W-1:0]     hi_dat, lo_dat, win_dat;
  logic [3:0]            req_num;
  logic [16:0]           drop_sum;
  logic                  capt, full, wr_acc, rd_acc;
  logic [RD_W-1:0]       ram_wr_dat, ram_rd_dat;

  // Requesters above the last winner take priority; otherwise wrap to the lowest index.
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    hi_dat  = '0;
    lo_dat  = '0;
    req_num = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      req_num = req_num + {3'd0, trace_we[i]};
      if (trace_we[i]) begin
        if (i > int'(last_q)) begin
          hi_vld = 1'b1;
          hi_id  = CH_W'(i);
          hi_dat = trace_wd[i*DATA_W +: DATA_W];
        end else begin
          lo_vld = 1'b1;
          lo_id  = CH_W'(i);
          lo_dat = trace_wd[i*DATA_W +: DATA_W];
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win_id  = hi_vld ? hi_id  : lo_id;
    win_dat = hi_vld ? hi_dat : lo_dat;
  end

  assign capt     = (state_q == ST_CAPT) || (state_q == ST_POST);
  assign full     = (cnt_q == FULL_CNT);
  assign wr_acc   = capt && win_vld && !(trace_mode && full);
  assign rd_acc   = trace_re && !trace_enb && (cnt_q != '0);
  assign drop_sum = {1'b0, drop_q} + {13'd0, req_num} - 17'd1;

`ifdef TRACE_BUF_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n)       ts_q <= '0;
    else if (trace_clr) ts_q <= '0;
    else                ts_q <= ts_q + 16'd1;
  end

  assign ram_wr_dat = {ts_q, win_id, win_dat};
`else
  assign ram_wr_dat = {win_id, win_dat};
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    last_d   = last_q;
    vld1_d   = rd_acc;
    vld2_d   = vld1_q;
    rd_dat_d = vld1_q ? ram_rd_dat : '0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      last_d   = win_id;
      // Ring mode at capacity: the oldest entry is overwritten, so the read side moves too.
      if (full) rd_ptr_d = rd_ptr_q + PTR_ONE;
      else      cnt_d    = cnt_q + CNT_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      cnt_d    = cnt_q - CNT_ONE;
    end
    if (capt && win_vld) drop_d = drop_sum[16] ? DROP_MAX : drop_sum[15:0];

    unique case (state_q)
      ST_IDLE: if (trace_enb) state_d = ST_CAPT;
      ST_CAPT: begin
        if (trace_mode && full) begin
          state_d = ST_STOP;
        end else if (trace_trig) begin
          post_d  = trace_post;
          state_d = (trace_post == '0) ? ST_STOP : ST_POST;
        end
      end
      ST_POST: begin
        if (trace_mode && full) begin
          state_d = ST_STOP;
        end else if (wr_acc) begin
          post_d = post_q - PTR_ONE;
          if (post_q == PTR_ONE) state_d = ST_STOP;
        end
      end
      ST_STOP: state_d = ST_STOP;
      default: state_d = ST_IDLE;
    endcase
    if (!trace_enb && state_q != ST_STOP) state_d = ST_IDLE;

    if (trace_clr) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      post_d   = '0;
      cnt_d    = '0;
      drop_d   = '0;
      last_d   = LAST_RST;
      vld1_d   = 1'b0;
      vld2_d   = 1'b0;
      rd_dat_d = '0;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      post_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      last_q   <= LAST_RST;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      post_q   <= post_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  trace_buf_sdpram #(
    .WIDTH (RD_W),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .user_clk (user_clk),
    .wr_en    (wr_acc),
    .wr_addr  (wr_ptr_q),
    .wr_dat   (ram_wr_dat),
    .rd_en    (rd_acc),
    .rd_addr  (rd_ptr_q),
    .rd_dat   (ram_rd_dat)
  );

  assign trace_rd     = rd_dat_q;
  assign trace_rd_vld = vld2_q;
  assign trace_cnt    = cnt_q;
  assign trace_drop   = drop_q;
  assign trace_state  = state_q;

endmodule

// File: tb/tb_trace_buf_mc.sv
// Directed bench for trace_buf_mc in its default build (CH_NUM=2, DATA_W=32, DEPTH=1024).
module tb_trace_buf_mc;

  logic        user_clk;
  logic        reset_n;
  logic        trace_clr;
  logic        trace_enb;
  logic        trace_mode;
  logic [1:0]  trace_we;
  logic [63:0] trace_wd;
  logic        trace_trig;
  logic [9:0]  trace_post;
  logic        trace_re;
  logic [32:0] trace_rd;
  logic        trace_rd_vld;
  logic [10:0] trace_cnt;
  logic [15:0] trace_drop;
  logic [1:0]  trace_state;

  int n_chk = 0;
  int n_err = 0;

  trace_buf_mc dut (
    .user_clk     (user_clk),
    .reset_n      (reset_n),
    .trace_clr    (trace_clr),
    .trace_enb    (trace_enb),
    .trace_mode   (trace_mode),
    .trace_we     (trace_we),
    .trace_wd     (trace_wd),
    .trace_trig   (trace_trig),
    .trace_post   (trace_post),
    .trace_re     (trace_re),
    .trace_rd     (trace_rd),
    .trace_rd_vld (trace_rd_vld),
    .trace_cnt    (trace_cnt),
    .trace_drop   (trace_drop),
    .trace_state  (trace_state)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic clear();
    trace_clr = 1'b1;
    step();
    trace_clr = 1'b0;
  endtask

  // Returns vld/data one cycle after the strobe edge and again one cycle later.
  task automatic do_read(output logic [32:0] d1, output logic v1,
                         output logic [32:0] d2, output logic v2);
    trace_re = 1'b1;
    step();
    trace_re = 1'b0;
    v1 = trace_rd_vld;
    d1 = trace_rd;
    step();
    v2 = trace_rd_vld;
    d2 = trace_rd;
  endtask

  logic [32:0] d1, d2;
  logic        v1, v2;

  initial begin
    reset_n    = 1'b0;
    trace_clr  = 1'b0;
    trace_enb  = 1'b0;
    trace_mode = 1'b0;
    trace_we   = 2'b00;
    trace_wd   = '0;
    trace_trig = 1'b0;
    trace_post = '0;
    trace_re   = 1'b0;
    #12;
    check("rst_state", 64'(trace_state), 64'd0);
    check("rst_cnt",   64'(trace_cnt),   64'd0);
    check("rst_drop",  64'(trace_drop),  64'd0);
    check("rst_vld",   64'(trace_rd_vld), 64'd0);
    check("rst_rd",    64'(trace_rd),    64'd0);
    #10 reset_n = 1'b1;
    step();

    // Basic ch0 capture and readout latency
    trace_enb = 1'b1;
    step();
    check("t1_capt", 64'(trace_state), 64'd1);
    for (int i = 0; i < 4; i++) begin
      trace_we = 2'b01;
      trace_wd = 64'(32'h11 + i);
      step();
    end
    trace_we  = 2'b00;
    trace_enb = 1'b0;
    step();
    check("t1_cnt4", 64'(trace_cnt), 64'd4);
    check("t1_idle", 64'(trace_state), 64'd0);
    for (int i = 0; i < 4; i++) begin
      do_read(d1, v1, d2, v2);
      check("t1_vld_early", 64'(v1), 64'd0);
      check("t1_rd_zero",   64'(d1), 64'd0);
      check("t1_vld",       64'(v2), 64'd1);
      check("t1_data",      64'(d2), 64'(32'h11 + i));
    end
    check("t1_cnt0", 64'(trace_cnt), 64'd0);
    do_read(d1, v1, d2, v2);
    check("t1_empty_vld", 64'(v2), 64'd0);
    step();
    check("t1_empty_vld2", 64'(trace_rd_vld), 64'd0);

    // Wrap mode overflow
    clear();
    trace_mode = 1'b0;
    trace_enb  = 1'b1;
    step();
    for (int i = 0; i < 1030; i++) begin
      trace_we = 2'b01;
      trace_wd = 64'(i);
      step();
    end
    trace_we  = 2'b00;
    trace_enb = 1'b0;
    step();
    check("t2_cnt", 64'(trace_cnt), 64'd1024);
    for (int i = 0; i < 1024; i++) begin
      do_read(d1, v1, d2, v2);
      if (i == 0)    check("t2_first", 64'(d2), 64'd6);
      if (i == 1023) check("t2_last",  64'(d2), 64'd1029);
    end
    check("t2_cnt0", 64'(trace_cnt), 64'd0);

    // Stop-when-full
    clear();
    trace_mode = 1'b1;
    trace_enb  = 1'b1;
    step();
    for (int i = 0; i < 1030; i++) begin
      trace_we = 2'b01;
      trace_wd = 64'(i);
      step();
      if (i == 1024) check("t3_stop_early", 64'(trace_state), 64'd3);
    end
    trace_we = 2'b00;
    check("t3_state", 64'(trace_state), 64'd3);
    check("t3_cnt",   64'(trace_cnt),   64'd1024);
    trace_enb = 1'b0;
    step();
    check("t3_hold", 64'(trace_state), 64'd3);
    for (int i = 0; i < 1024; i++) begin
      do_read(d1, v1, d2, v2);
      if (i == 0)    check("t3_first", 64'(d2), 64'd0);
      if (i == 1023) check("t3_last",  64'(d2), 64'd1023);
    end
    check("t3_cnt0", 64'(trace_cnt), 64'd0);

    // Round-robin arbitration and drop counting
    clear();
    trace_mode = 1'b0;
    trace_enb  = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      trace_we = 2'b11;
      trace_wd = {32'(32'hB0 + i), 32'(32'hA0 + i)};
      step();
    end
    trace_we  = 2'b00;
    trace_enb = 1'b0;
    step();
    check("t4_drop", 64'(trace_drop), 64'd4);
    check("t4_cnt",  64'(trace_cnt),  64'd4);
    do_read(d1, v1, d2, v2);
    check("t4_w0", 64'(d2), 64'h0_0000_00A0);
    do_read(d1, v1, d2, v2);
    check("t4_w1", 64'(d2), 64'h1_0000_00B1);
    do_read(d1, v1, d2, v2);
    check("t4_w2", 64'(d2), 64'h0_0000_00A2);
    do_read(d1, v1, d2, v2);
    check("t4_w3", 64'(d2), 64'h1_0000_00B3);

    // Trigger with post-trigger count
    clear();
    trace_post = 10'd3;
    trace_enb  = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      trace_we = 2'b01;
      trace_wd = 64'(i);
      step();
    end
    trace_we   = 2'b00;
    trace_trig = 1'b1;
    step();
    trace_trig = 1'b0;
    check("t5_post", 64'(trace_state), 64'd2);
    for (int i = 0; i < 20; i++) begin
      trace_we = 2'b01;
      trace_wd = 64'(100 + i);
      step();
    end
    trace_we = 2'b00;
    check("t5_cnt",   64'(trace_cnt),   64'd13);
    check("t5_state", 64'(trace_state), 64'd3);
    trace_trig = 1'b1;
    step();
    trace_trig = 1'b0;
    step();
    check("t5_trig_stop", 64'(trace_state), 64'd3);
    check("t5_cnt_hold",  64'(trace_cnt),   64'd13);

    // Clear during an in-flight read
    clear();
    trace_enb = 1'b1;
    step();
    trace_we = 2'b11;
    trace_wd = {32'hC1, 32'hC0};
    step();
    trace_we  = 2'b00;
    trace_enb = 1'b0;
    step();
    check("t6_pre_drop", 64'(trace_drop), 64'd1);
    trace_re = 1'b1;
    step();
    trace_re  = 1'b0;
    trace_clr = 1'b1;
    step();
    trace_clr = 1'b0;
    check("t6_vld_a", 64'(trace_rd_vld), 64'd0);
    check("t6_rd",    64'(trace_rd),     64'd0);
    step();
    check("t6_vld_b", 64'(trace_rd_vld), 64'd0);
    check("t6_cnt",   64'(trace_cnt),    64'd0);
    check("t6_drop",  64'(trace_drop),   64'd0);
    check("t6_state", 64'(trace_state),  64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
